// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster counters with ce-gated, delay-matched sync/blank/strobe outputs.
module vga_timing_gen #(
   parameter int CW         = 10,
   parameter int W_DISPLAY  = 640,
   parameter int W_FRONT    = 16,
   parameter int W_SYNC     = 96,
   parameter int W_BACK     = 48,
   parameter int H_DISPLAY  = 480,
   parameter int H_BOTTOM   = 10,
   parameter int H_SYNC     = 2,
   parameter int H_TOP      = 33,
   parameter bit HSYNC_POL  = 1'b0,
   parameter bit VSYNC_POL  = 1'b0,
   parameter int PIPE_DELAY = 0,
   parameter int FRAME_CW   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ce,
   output logic [CW-1:0]       x,
   output logic [CW-1:0]       y,
   output logic                h_sync,
   output logic                v_sync,
   output logic                display_on,
   output logic                line_start,
   output logic                frame_start,
   output logic [FRAME_CW-1:0] frame_count
);
   localparam int W_TOTAL  = W_DISPLAY + W_FRONT + W_SYNC + W_BACK;
   localparam int H_TOTAL  = H_DISPLAY + H_BOTTOM + H_SYNC + H_TOP;
   localparam int HS_START = W_DISPLAY + W_FRONT;
   localparam int VS_START = H_DISPLAY + H_BOTTOM;
   // status bits: {hsync_active, vsync_active, visible, line_start, frame_start}
   logic [4:0] pipe [PIPE_DELAY+1];
   logic [4:0] status;
   logic       x_end, y_end;
   always_comb begin
      x_end  = x == CW'(W_TOTAL - 1);
      y_end  = y == CW'(H_TOTAL - 1);
      status = {x >= CW'(HS_START) && x <= CW'(HS_START + W_SYNC - 1),
                y >= CW'(VS_START) && y <= CW'(VS_START + H_SYNC - 1),
                x < CW'(W_DISPLAY) && y < CW'(H_DISPLAY),
                x == '0,
                x == '0 && y == '0};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         x           <= '0;
         y           <= '0;
         frame_count <= '0;
      end else if (ce) begin
         x <= x_end ? '0 : x + 1'b1;
         if (x_end) begin
            y <= y_end ? '0 : y + 1'b1;
            if (y_end) frame_count <= frame_count + 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= PIPE_DELAY; i++) pipe[i] <= '0;
      end else if (ce) begin
         pipe[0] <= status;
         for (int i = 1; i <= PIPE_DELAY; i++) pipe[i] <= pipe[i-1];
      end
   end
   // strobes are gated by ce so a stalled pipeline never stretches them
   assign h_sync      = ~(pipe[PIPE_DELAY][4] ^ HSYNC_POL);
   assign v_sync      = ~(pipe[PIPE_DELAY][3] ^ VSYNC_POL);
   assign display_on  = pipe[PIPE_DELAY][2];
   assign line_start  = pipe[PIPE_DELAY][1] & ce;
   assign frame_start = pipe[PIPE_DELAY][0] & ce;
endmodule
